fpa_control_fsm: RTL and testbench

- Sequencing controller for FloatingPointAdder.
- Consumes ExpDiff and datapath status; drives all mux selects, the pre-add shift amount, the normalizer enable and the round/renormalize loop.
- Flags special cases and produces the Done/Zero/Inf/Nan result qualifiers.
- Plugs into the adder's control slot; one operation in flight at a time.

---
 rtl/fpa_control_fsm_pkg.sv | 22 ++
 rtl/fpa_control_fsm_special_detect.sv | 27 ++
 rtl/fpa_control_fsm.sv | 155 +++++++++++++++
 tb/tb_fpa_control_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_control_fsm_pkg.sv
// Shared types and constants for the floating-point adder control FSM.
package fpa_control_fsm_pkg;

    localparam int unsigned FPA_MANT_W    = 24;
    localparam int unsigned FPA_SHIFT_SAT = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_RENORM,
        ST_DONE
    } fpa_state_t;

    // Magnitude of a signed 9-bit exponent difference; -256 maps to 256.
    function automatic logic [8:0] abs_diff(input logic signed [8:0] d);
        return d[8] ? (~d + 9'd1) : d;
    endfunction

endpackage

// File: rtl/fpa_control_fsm_special_detect.sv
// Combinational special-operand classifier (NaN > Inf > Zero priority).
module fpa_special_detect (
    input  logic ExpAMax,
    input  logic ExpBMax,
    input  logic ExpAZero,
    input  logic ExpBZero,
    input  logic FracANonZero,
    input  logic FracBNonZero,
    input  logic SignA,
    input  logic SignB,
    output logic IsNan,
    output logic IsInf,
    output logic IsZero
);

    logic a_inf, b_inf;

    always_comb begin
        a_inf  = ExpAMax & ~FracANonZero;
        b_inf  = ExpBMax & ~FracBNonZero;
        IsNan  = (ExpAMax & FracANonZero) | (ExpBMax & FracBNonZero) |
                 (a_inf & b_inf & (SignA ^ SignB));
        IsInf  = (a_inf | b_inf) & ~IsNan;
        IsZero = ExpAZero & ~FracANonZero & ExpBZero & ~FracBNonZero & ~IsNan & ~IsInf;
    end

endmodule

// File: rtl/fpa_control_fsm.sv
// Sequencing controller for the floating-point adder.
// Optional special-operand bypass enabled by defining FPA_SPECIAL_CASE_EN.
module fpa_control_fsm
    import fpa_control_fsm_pkg::*;
#(
    parameter int unsigned MANT_W     = FPA_MANT_W,
    parameter int unsigned SHIFT_W    = 5,
    parameter int unsigned SHIFT_SAT  = FPA_SHIFT_SAT,
    parameter int unsigned MAX_RENORM = 1
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Go,
    input  logic signed [8:0]  ExpDiff,
    input  logic               FracAGreaterEq,
    input  logic               ExpAMax,
    input  logic               ExpBMax,
    input  logic               ExpAZero,
    input  logic               ExpBZero,
    input  logic               FracANonZero,
    input  logic               FracBNonZero,
    input  logic               SignA,
    input  logic               SignB,
    input  logic               FFOValid,
    input  logic               RoundOverflow,
    input  logic               ExpOverflow,
    output logic               SelExpMux,
    output logic               SelSRMuxL,
    output logic               SelSRMuxG,
    output logic [SHIFT_W-1:0] ShiftRightAmount,
    output logic               SREn,
    output logic               SelManMuxR,
    output logic               SelExpMuxR,
    output logic               Busy,
    output logic               Done,
    output logic               Zero,
    output logic               Inf,
    output logic               Nan
);

    // Shifting past mantissa plus round bit is all sticky, so never exceed it.
    localparam int unsigned SAT_EFF = (SHIFT_SAT > MANT_W + 1) ? MANT_W + 1 : SHIFT_SAT;
    localparam int unsigned RC_W    = $clog2(MAX_RENORM + 1);

    fpa_state_t        state;
    logic [RC_W-1:0]   renorm_cnt;
    logic [8:0]        mag;
    logic [SHIFT_W-1:0] shift_next;
    logic              a_large;

    always_comb begin
        mag        = abs_diff(ExpDiff);
        shift_next = (mag > 9'(SAT_EFF)) ? SHIFT_W'(SAT_EFF) : SHIFT_W'(mag);
        a_large    = (~ExpDiff[8] & (ExpDiff != '0)) | ((ExpDiff == '0) & FracAGreaterEq);
    end

`ifdef FPA_SPECIAL_CASE_EN
    logic is_nan, is_inf, is_zero;

    fpa_special_detect u_special (
        .ExpAMax      (ExpAMax),
        .ExpBMax      (ExpBMax),
        .ExpAZero     (ExpAZero),
        .ExpBZero     (ExpBZero),
        .FracANonZero (FracANonZero),
        .FracBNonZero (FracBNonZero),
        .SignA        (SignA),
        .SignB        (SignB),
        .IsNan        (is_nan),
        .IsInf        (is_inf),
        .IsZero       (is_zero)
    );
`else
    logic unused_special;
    assign unused_special = ^{ExpAMax, ExpBMax, ExpAZero, ExpBZero,
                              FracANonZero, FracBNonZero, SignA, SignB};
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= ST_IDLE;
            renorm_cnt       <= '0;
            SelExpMux        <= 1'b0;
            SelSRMuxL        <= 1'b0;
            SelSRMuxG        <= 1'b0;
            ShiftRightAmount <= '0;
            SREn             <= 1'b0;
            SelManMuxR       <= 1'b0;
            SelExpMuxR       <= 1'b0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Zero             <= 1'b0;
            Inf              <= 1'b0;
            Nan              <= 1'b0;
        end else begin
            // Single-cycle strobes; asserted only by the transition that needs them.
            SREn       <= 1'b0;
            SelManMuxR <= 1'b0;
            SelExpMuxR <= 1'b0;
            Done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Go) begin
                        SelExpMux        <= a_large;
                        SelSRMuxG        <= a_large;
                        SelSRMuxL        <= ~a_large;
                        ShiftRightAmount <= shift_next;
                        renorm_cnt       <= '0;
                        Busy             <= 1'b1;
`ifdef FPA_SPECIAL_CASE_EN
                        Nan              <= is_nan;
                        Inf              <= is_inf;
                        Zero             <= is_zero;
                        state            <= (is_nan | is_inf | is_zero) ? ST_DONE : ST_ALIGN;
`else
                        Nan              <= 1'b0;
                        Inf              <= 1'b0;
                        Zero             <= 1'b0;
                        state            <= ST_ALIGN;
`endif
                    end
                end
                ST_ALIGN: state <= ST_ADD;
                ST_ADD:   state <= ST_NORM;
                ST_NORM: begin
                    SREn  <= 1'b1;
                    Zero  <= ~FFOValid;
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (RoundOverflow && (renorm_cnt < RC_W'(MAX_RENORM))) begin
                        state <= ST_RENORM;
                    end else begin
                        // A zero sum cannot overflow; keep Zero and Inf exclusive.
                        Inf   <= ExpOverflow & ~Zero;
                        state <= ST_DONE;
                    end
                end
                ST_RENORM: begin
                    SelManMuxR <= 1'b1;
                    SelExpMuxR <= 1'b1;
                    renorm_cnt <= renorm_cnt + 1'b1;
                    state      <= ST_NORM;
                end
                ST_DONE: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_control_fsm.sv
// Self-checking bench for fpa_control_fsm: directed plus randomized operations
// checked against a latency/flag timeline model.
module tb_fpa_control_fsm;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic              Go;
    logic signed [8:0] ExpDiff;
    logic              FracAGreaterEq;
    logic              ExpAMax, ExpBMax, ExpAZero, ExpBZero;
    logic              FracANonZero, FracBNonZero, SignA, SignB;
    logic              FFOValid, RoundOverflow, ExpOverflow;
    logic              SelExpMux, SelSRMuxL, SelSRMuxG;
    logic [4:0]        ShiftRightAmount;
    logic              SREn, SelManMuxR, SelExpMuxR, Busy, Done, Zero, Inf, Nan;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 Clock = ~Clock;

    fpa_control_fsm #(
        .MANT_W     (24),
        .SHIFT_W    (5),
        .SHIFT_SAT  (25),
        .MAX_RENORM (1)
    ) dut (
        .Clock            (Clock),
        .Reset_n          (Reset_n),
        .Go               (Go),
        .ExpDiff          (ExpDiff),
        .FracAGreaterEq   (FracAGreaterEq),
        .ExpAMax          (ExpAMax),
        .ExpBMax          (ExpBMax),
        .ExpAZero         (ExpAZero),
        .ExpBZero         (ExpBZero),
        .FracANonZero     (FracANonZero),
        .FracBNonZero     (FracBNonZero),
        .SignA            (SignA),
        .SignB            (SignB),
        .FFOValid         (FFOValid),
        .RoundOverflow    (RoundOverflow),
        .ExpOverflow      (ExpOverflow),
        .SelExpMux        (SelExpMux),
        .SelSRMuxL        (SelSRMuxL),
        .SelSRMuxG        (SelSRMuxG),
        .ShiftRightAmount (ShiftRightAmount),
        .SREn             (SREn),
        .SelManMuxR       (SelManMuxR),
        .SelExpMuxR       (SelExpMuxR),
        .Busy             (Busy),
        .Done             (Done),
        .Zero             (Zero),
        .Inf              (Inf),
        .Nan              (Nan)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightAmount, SREn,
                              SelManMuxR, SelExpMuxR, Busy, Done, Zero, Inf, Nan}, 16'd0);
    endtask

    // One operation. p1/p2 = {FFOValid, RoundOverflow, ExpOverflow} for pass 1/2.
    // sp = {ExpAMax, ExpBMax, ExpAZero, ExpBZero, FracANonZero, FracBNonZero, SignA, SignB}.
    task automatic run_op(input int diff, input logic fge, input logic [2:0] p1,
                          input logic [2:0] p2, input logic [7:0] sp,
                          input logic go_align, input logic go_late);
        logic a_large, renorm, spc, e_zero, e_inf, e_nan;
        logic a_nan_op, b_nan_op, a_inf_op, b_inf_op, a_zero_op, b_zero_op;
        logic [2:0] last;
        int shamt, done_cyc;

        a_large = (diff > 0) || (diff == 0 && fge);
        shamt   = (diff < 0) ? -diff : diff;
        if (shamt > 25) shamt = 25;

        a_nan_op  = sp[7] && sp[3];
        b_nan_op  = sp[6] && sp[2];
        a_inf_op  = sp[7] && !sp[3];
        b_inf_op  = sp[6] && !sp[2];
        a_zero_op = sp[5] && !sp[3];
        b_zero_op = sp[4] && !sp[2];
`ifdef FPA_SPECIAL_CASE_EN
        e_nan  = a_nan_op || b_nan_op || (a_inf_op && b_inf_op && (sp[1] != sp[0]));
        e_inf  = (a_inf_op || b_inf_op) && !e_nan;
        e_zero = a_zero_op && b_zero_op && !e_nan && !e_inf;
        spc    = e_nan || e_inf || e_zero;
`else
        spc    = 1'b0;
        e_nan  = 1'b0;
        e_inf  = 1'b0;
        e_zero = 1'b0;
`endif
        renorm = 1'b0;
        if (spc) begin
            done_cyc = 1;
        end else begin
            renorm   = p1[1];
            last     = renorm ? p2 : p1;
            e_zero   = !last[2];
            e_inf    = last[0] && !e_zero;
            done_cyc = renorm ? 8 : 5;
        end

        ExpDiff        = 9'(diff);
        FracAGreaterEq = fge;
        {ExpAMax, ExpBMax, ExpAZero, ExpBZero, FracANonZero, FracBNonZero, SignA, SignB} = sp;
        {FFOValid, RoundOverflow, ExpOverflow} = p1;
        Go = 1'b1;
        @(posedge Clock); #1;
        Go = 1'b0;

        for (int k = 0; k <= done_cyc; k++) begin
            if (k > 0) begin
                @(posedge Clock); #1;
            end
            chk($sformatf("busy_c%0d", k), Busy, (k < done_cyc));
            chk($sformatf("done_c%0d", k), Done, (k == done_cyc));
            chk($sformatf("sren_c%0d", k), SREn, !spc && (k == 3 || (renorm && k == 6)));
            chk($sformatf("selmanr_c%0d", k), SelManMuxR, renorm && k == 5);
            chk($sformatf("selexpr_c%0d", k), SelExpMuxR, renorm && k == 5);
            if (k == 0) begin
                chk("selexpmux", SelExpMux, a_large);
                chk("selsrg", SelSRMuxG, a_large);
                chk("selsrl", SelSRMuxL, !a_large);
                chk("shift", ShiftRightAmount, 16'(shamt));
                if (!spc) chk("flags_clear", {Zero, Inf, Nan}, 3'b000);
                Go = go_align;
            end
            if (k == 1) Go = 1'b0;
            if (k == 4) {FFOValid, RoundOverflow, ExpOverflow} = p2;
            if (go_late && k == done_cyc - 1) Go = 1'b1;
            if (k == done_cyc) begin
                Go = 1'b0;
                chk("zero", Zero, e_zero);
                chk("inf", Inf, e_inf);
                chk("nan", Nan, e_nan);
            end
        end
        @(posedge Clock); #1;
        chk("idle_busy", Busy, 1'b0);
        chk("idle_done", Done, 1'b0);
        chk("flags_hold", {Zero, Inf, Nan}, {e_zero, e_inf, e_nan});
        chk("sel_hold", {SelSRMuxG, ShiftRightAmount}, {a_large, 5'(shamt)});
    endtask

    initial begin
        Reset_n = 1'b0;
        Go = 1'b0;
        ExpDiff = '0;
        FracAGreaterEq = 1'b0;
        {ExpAMax, ExpBMax, ExpAZero, ExpBZero, FracANonZero, FracBNonZero, SignA, SignB} = '0;
        {FFOValid, RoundOverflow, ExpOverflow} = 3'b100;
        #12;
        chk_all_zero("reset");
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        chk_all_zero("post_reset");

        // Nominal, alignment extremes and saturation boundaries
        run_op(0, 1'b1, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(-30, 1'b1, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(3, 1'b0, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(0, 1'b0, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(-256, 1'b0, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(255, 1'b0, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(25, 1'b0, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(-24, 1'b1, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);
        // Renormalize once, then overflow held
        run_op(1, 1'b0, 3'b110, 3'b100, 8'h00, 1'b0, 1'b0);
        run_op(1, 1'b0, 3'b110, 3'b110, 8'h00, 1'b0, 1'b0);
        // Zero sum, exponent overflow, and both together
        run_op(0, 1'b1, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);
        run_op(2, 1'b1, 3'b101, 3'b101, 8'h00, 1'b0, 1'b0);
        run_op(2, 1'b1, 3'b001, 3'b001, 8'h00, 1'b0, 1'b0);
        run_op(-2, 1'b1, 3'b110, 3'b101, 8'h00, 1'b0, 1'b0);
        // Go during ALIGN and during DONE is ignored
        run_op(4, 1'b0, 3'b100, 3'b100, 8'h00, 1'b1, 1'b1);
        // Special operands: NaN A, +Inf + -Inf, +Inf + +Inf, 0 + 0
        run_op(0, 1'b1, 3'b100, 3'b100, 8'b1000_1000, 1'b0, 1'b0);
        run_op(0, 1'b1, 3'b100, 3'b100, 8'b1100_0001, 1'b0, 1'b0);
        run_op(0, 1'b1, 3'b100, 3'b100, 8'b1100_0000, 1'b0, 1'b0);
        run_op(0, 1'b0, 3'b100, 3'b100, 8'b0011_0000, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] sp;
            sp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            run_op(int'($urandom_range(0, 511)) - 256, 1'($urandom), 3'($urandom),
                   3'($urandom), sp, 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset while in ADD aborts without Done
        ExpDiff = 9'sd7;
        {ExpAMax, ExpBMax, ExpAZero, ExpBZero, FracANonZero, FracBNonZero, SignA, SignB} = '0;
        {FFOValid, RoundOverflow, ExpOverflow} = 3'b100;
        Go = 1'b1;
        @(posedge Clock); #1;
        Go = 1'b0;
        @(posedge Clock); #1;
        chk("pre_abort_busy", Busy, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); #1;
            chk($sformatf("abort_nodone_%0d", k), Done, 1'b0);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        chk_all_zero("after_abort");
        run_op(-5, 1'b0, 3'b100, 3'b100, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
